// File: rtl/waveform_readout_ctrl.sv
// Waveform readout controller: gates the trigger, waits for the capture window
// to close, then streams one checksummed frame per event to the UART.
module waveform_readout_ctrl #(
  parameter int         NSAMPLES = 32,
  parameter logic [7:0] SYNC0    = 8'hA5,
  parameter logic [7:0] SYNC1    = 8'h5A,
  parameter int         HOLDOFF  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run_enable,
  input  logic                        trig_in,
  output logic                        trig_out,
  input  logic                        long_trigger,
  input  logic [31:0]                 pulse_height,
  output logic [$clog2(NSAMPLES)-1:0] wf_addr,
  input  logic [13:0]                 wf_data,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [7:0]                  event_count,
  output logic [15:0]                 drop_count,
  output logic [2:0]                  dbg_state
);

  localparam int              AW    = $clog2(NSAMPLES);
  localparam int              HW    = $clog2(HOLDOFF + 1);
  localparam logic [AW-1:0]   LAST  = AW'(NSAMPLES - 1);
  localparam logic [HW-1:0]   HLAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SEND_HDR = 3'd2,
    ST_SEND_PH  = 3'd3,
    ST_SEND_WF  = 3'd4,
    ST_SEND_CK  = 3'd5,
    ST_HOLDOFF  = 3'd6
  } state_t;

  state_t        state, state_next;
  logic          lt_prev, trig_prev;
  logic [31:0]   ph_reg;
  logic [7:0]    ck;
  logic [1:0]    idx;
  logic [AW-1:0] samp;
  logic          sub;
  logic [7:0]    wf_lo;
  logic [HW-1:0] hold_cnt;
  logic          lt_fall, drop_hit, xfer, ck_en;

  // Handshake: a byte moves when tx_valid & tx_ready; while stalled, tx_valid
  // stays high and tx_data is held because every source only advances on xfer.
  assign lt_fall   = lt_prev & ~long_trigger;
  assign drop_hit  = trig_in & ~trig_prev & ((state != ST_IDLE) | ~run_enable);
  assign xfer      = tx_valid & tx_ready;
  assign ck_en     = ((state == ST_SEND_HDR) && (idx == 2'd2)) ||
                     (state == ST_SEND_PH) || (state == ST_SEND_WF);
  assign trig_out  = trig_in & run_enable & (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      ST_IDLE:    if (long_trigger) state_next = ST_CAPTURE;
      ST_CAPTURE: if (lt_fall) state_next = ST_SEND_HDR;
      ST_SEND_HDR: begin
        tx_valid = 1'b1;
        case (idx)
          2'd0:    tx_data = SYNC0;
          2'd1:    tx_data = SYNC1;
          default: tx_data = event_count;
        endcase
        if (tx_ready && idx == 2'd2) state_next = ST_SEND_PH;
      end
      ST_SEND_PH: begin
        tx_valid = 1'b1;
        case (idx)
          2'd0:    tx_data = ph_reg[31:24];
          2'd1:    tx_data = ph_reg[23:16];
          2'd2:    tx_data = ph_reg[15:8];
          default: tx_data = ph_reg[7:0];
        endcase
        if (tx_ready && idx == 2'd3) state_next = ST_SEND_WF;
      end
      ST_SEND_WF: begin
        tx_valid = 1'b1;
        tx_data  = sub ? wf_lo : {2'b00, wf_data[13:8]};
        if (tx_ready && sub && samp == LAST) state_next = ST_SEND_CK;
      end
      ST_SEND_CK: begin
        tx_valid = 1'b1;
        tx_data  = ck;
        if (tx_ready) state_next = ST_HOLDOFF;
      end
      ST_HOLDOFF: if (hold_cnt == HLAST) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_prev     <= 1'b0;
      trig_prev   <= 1'b0;
      ph_reg      <= '0;
      ck          <= '0;
      idx         <= '0;
      samp        <= '0;
      sub         <= 1'b0;
      wf_lo       <= '0;
      wf_addr     <= '0;
      hold_cnt    <= '0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      lt_prev   <= long_trigger;
      trig_prev <= trig_in;
      if (drop_hit && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (xfer && ck_en) ck <= ck + tx_data;
      case (state)
        ST_CAPTURE: if (lt_fall) begin
          ph_reg <= pulse_height;
          ck     <= '0;
          idx    <= '0;
          samp   <= '0;
          sub    <= 1'b0;
        end
        ST_SEND_HDR, ST_SEND_PH: if (xfer) begin
          idx <= (state == ST_SEND_HDR && idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        ST_SEND_WF: if (xfer) begin
          // The low byte is parked in wf_lo so wf_addr can move to the next
          // sample while it waits, giving the RAM its read cycle.
          if (!sub) begin
            wf_lo <= wf_data[7:0];
            sub   <= 1'b1;
            if (samp != LAST) wf_addr <= samp + AW'(1);
          end else begin
            sub  <= 1'b0;
            samp <= samp + AW'(1);
          end
        end
        ST_SEND_CK: if (xfer) event_count <= event_count + 8'd1;
        ST_HOLDOFF: hold_cnt <= hold_cnt + HW'(1);
        default: ;
      endcase
      if (state_next == ST_IDLE) begin
        wf_addr  <= '0;
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_readout_ctrl.sv
// Self-checking bench for waveform_readout_ctrl: frame contents from a byte-level
// frame model, handshake behaviour, trigger gating, drop and event counters.
module tb_waveform_readout_ctrl;
  localparam int NS        = 32;
  localparam int HOLD      = 16;
  localparam int FRAME_LEN = 2 + 1 + 4 + 2 * NS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_enable = 1'b0;
  logic        trig_in = 1'b0;
  logic        long_trigger = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] pulse_height = '0;
  logic [13:0] wf_data = '0;
  logic        trig_out, tx_valid, busy;
  logic [4:0]  wf_addr;
  logic [7:0]  tx_data, event_count;
  logic [15:0] drop_count;
  logic [2:0]  dbg_state;

  waveform_readout_ctrl #(.NSAMPLES(NS), .SYNC0(8'hA5), .SYNC1(8'h5A), .HOLDOFF(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .run_enable(run_enable), .trig_in(trig_in),
    .trig_out(trig_out), .long_trigger(long_trigger), .pulse_height(pulse_height),
    .wf_addr(wf_addr), .wf_data(wf_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .event_count(event_count),
    .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // clock / reset / waveform memory with one-cycle read latency
  always #5 clk = ~clk;
  logic [13:0] mem [NS];
  always @(posedge clk) wf_data <= mem[wf_addr];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  bit          timed_out;
  int          stall_viol, leak_cnt, span, hold_cycles;
  logic [7:0]  exp_events;
  logic [15:0] exp_drops;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame: sync bytes, count, PH big-endian, hi/lo per sample, sum.
  function automatic void build_frame(input logic [7:0] cnt, input logic [31:0] ph);
    int sum;
    int b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(cnt);
    sum = cnt;
    for (int k = 3; k >= 0; k--) begin
      b = (ph >> (8 * k)) & 255;
      exp_q.push_back(8'(b));
      sum += b;
    end
    for (int i = 0; i < NS; i++) begin
      b = mem[i] / 256;
      exp_q.push_back(8'(b));
      sum += b;
      b = mem[i] % 256;
      exp_q.push_back(8'(b));
      sum += b;
    end
    exp_q.push_back(8'(sum % 256));
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    trig_in = 1'b0;
    long_trigger = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_events = 8'h00;
    exp_drops = 16'h0000;
  endtask

  task automatic start_event(input logic [31:0] ph, output logic trig_seen);
    @(posedge clk); #1;
    pulse_height = ph;
    trig_in = 1'b1;
    long_trigger = 1'b1;
    @(negedge clk) trig_seen = trig_out;
    @(posedge clk); #1;
    trig_in = 1'b0;
    repeat (30) @(posedge clk);
    #1 long_trigger = 1'b0;
  endtask

  // mode 0: ready always, 1: ready one cycle in three. inject: trigger pulses
  // during the waveform bytes and in holdoff. rd: drop run_enable mid-frame.
  task automatic collect_frame(input int mode, input bit inject, input bit rd);
    int cyc;
    int first_c;
    int last_c;
    bit prev_stall;
    logic [7:0] prev_data;
    cyc = 0; first_c = -1; last_c = -1; prev_stall = 0; prev_data = '0;
    got_q.delete();
    stall_viol = 0; leak_cnt = 0; hold_cycles = 0;
    while (got_q.size() < FRAME_LEN && cyc < 600) begin
      @(posedge clk); #1;
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      trig_in = inject && (got_q.size() == 20 || got_q.size() == 30 || got_q.size() == 40);
      if (rd && got_q.size() == 30) run_enable = 1'b0;
      @(negedge clk);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
      if (trig_out) leak_cnt++;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      cyc++;
    end
    timed_out = (got_q.size() < FRAME_LEN);
    span = last_c - first_c + 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      tx_ready = 1'b0;
      trig_in = inject && (c == 5 || c == HOLD - 1);
      @(negedge clk);
      if (trig_out) leak_cnt++;
      if (!busy) break;
      hold_cycles++;
    end
    trig_in = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %0h expected 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL reset_trig_out: got %0h expected 0", trig_out); end
    n_checks++; if (event_count !== 8'h00) begin n_fail++; $display("FAIL reset_event_count: got %0h expected 0", event_count); end
    n_checks++; if (drop_count !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_count: got %0h expected 0", drop_count); end
    n_checks++; if (wf_addr !== 5'd0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_addr_data: got %0h/%0h expected 0/0", wf_addr, tx_data); end
  endtask

  task automatic test_single_event();
    logic seen;
    int d;
    run_enable = 1'b1;
    for (int i = 0; i < NS; i++) mem[i] = 14'h100 + 14'(i);
    build_frame(exp_events, 32'h0000_01F4);
    start_event(32'h0000_01F4, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_trig_out: got %0h expected 1", seen); end
    collect_frame(0, 0, 0);
    exp_events = exp_events + 8'd1;
    d = first_diff();
    n_checks++; if (timed_out || d >= 0) begin n_fail++; $display("FAIL single_frame: first bad byte %0d got %0h expected %0h (size %0d)", d, (d >= 0 && d < got_q.size()) ? got_q[d] : 8'hxx, (d >= 0 && d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size()); end
    n_checks++; if (span !== FRAME_LEN) begin n_fail++; $display("FAIL single_no_bubble: got %0d cycles expected %0d", span, FRAME_LEN); end
    n_checks++; if (hold_cycles !== HOLD) begin n_fail++; $display("FAIL single_holdoff: got %0d expected %0d", hold_cycles, HOLD); end
    n_checks++; if (event_count !== exp_events) begin n_fail++; $display("FAIL single_event_count: got %0h expected %0h", event_count, exp_events); end
    n_checks++; if (wf_addr !== 5'd0 || drop_count !== exp_drops) begin n_fail++; $display("FAIL single_idle_state: got addr %0h drops %0h expected 0/%0h", wf_addr, drop_count, exp_drops); end
  endtask

  task automatic test_backpressure();
    logic seen;
    logic [31:0] ph;
    int d;
    for (int i = 0; i < NS; i++) mem[i] = 14'($urandom_range(0, 16383));
    ph = $urandom;
    build_frame(exp_events, ph);
    start_event(ph, seen);
    collect_frame(1, 0, 1);
    exp_events = exp_events + 8'd1;
    d = first_diff();
    n_checks++; if (timed_out || d >= 0) begin n_fail++; $display("FAIL bp_frame: first bad byte %0d got %0h expected %0h (size %0d)", d, (d >= 0 && d < got_q.size()) ? got_q[d] : 8'hxx, (d >= 0 && d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size()); end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
    n_checks++; if (event_count !== exp_events) begin n_fail++; $display("FAIL bp_event_count: got %0h expected %0h", event_count, exp_events); end
    n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL bp_drop_count: got %0h expected %0h", drop_count, exp_drops); end
    run_enable = 1'b1;
  endtask

  task automatic test_trig_while_busy();
    logic seen;
    logic [31:0] ph;
    int d;
    for (int i = 0; i < NS; i++) mem[i] = 14'($urandom_range(0, 16383));
    ph = $urandom;
    build_frame(exp_events, ph);
    start_event(ph, seen);
    collect_frame(0, 1, 0);
    exp_events = exp_events + 8'd1;
    exp_drops = exp_drops + 16'd5;
    d = first_diff();
    n_checks++; if (timed_out || d >= 0) begin n_fail++; $display("FAIL busy_frame: first bad byte %0d got %0h expected %0h (size %0d)", d, (d >= 0 && d < got_q.size()) ? got_q[d] : 8'hxx, (d >= 0 && d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size()); end
    n_checks++; if (leak_cnt !== 0) begin n_fail++; $display("FAIL busy_trig_out: got %0d cycles high expected 0", leak_cnt); end
    n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL busy_drop_count: got %0h expected %0h", drop_count, exp_drops); end
    @(posedge clk); #1 trig_in = 1'b1;
    @(negedge clk);
    n_checks++; if (trig_out !== 1'b1) begin n_fail++; $display("FAIL busy_first_idle_trig: got %0h expected 1", trig_out); end
    @(posedge clk); #1 trig_in = 1'b0;
    @(negedge clk);
    n_checks++; if (drop_count !== exp_drops || busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_accept: got drops %0h busy %0h expected %0h/0", drop_count, busy, exp_drops); end
  endtask

  task automatic test_run_disable();
    run_enable = 1'b0;
    for (int p = 0; p < 6; p++) begin
      @(posedge clk); #1 trig_in = 1'b1;
      @(negedge clk);
      n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL disabled_trig_out: got %0h expected 0", trig_out); end
      @(posedge clk); #1 trig_in = 1'b0;
      exp_drops = exp_drops + 16'd1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(negedge clk);
    n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL disabled_drop_count: got %0h expected %0h", drop_count, exp_drops); end
    n_checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL disabled_no_frame: got busy %0h valid %0h expected 0/0", busy, tx_valid); end
    run_enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic seen;
    logic [31:0] ph;
    int d;
    ph = $urandom;
    start_event(ph, seen);
    got_q.delete();
    for (int c = 0; c < 200 && got_q.size() < 20; c++) begin
      @(posedge clk); #1 tx_ready = 1'b1;
      @(negedge clk);
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
    @(posedge clk); #1;
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %0h expected 1", tx_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_drop: got valid %0h busy %0h expected 0/0", tx_valid, busy); end
    n_checks++; if (event_count !== 8'h00 || drop_count !== 16'h0000 || wf_addr !== 5'd0) begin n_fail++; $display("FAIL midrst_counts: got %0h/%0h/%0h expected 0/0/0", event_count, drop_count, wf_addr); end
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_events = 8'h00;
    exp_drops = 16'h0000;
    ph = $urandom;
    build_frame(exp_events, ph);
    start_event(ph, seen);
    collect_frame(0, 0, 0);
    exp_events = exp_events + 8'd1;
    d = first_diff();
    n_checks++; if (timed_out || d >= 0) begin n_fail++; $display("FAIL midrst_fresh_frame: first bad byte %0d got %0h expected %0h (size %0d)", d, (d >= 0 && d < got_q.size()) ? got_q[d] : 8'hxx, (d >= 0 && d < exp_q.size()) ? exp_q[d] : 8'hxx, got_q.size()); end
    n_checks++; if (event_count !== exp_events) begin n_fail++; $display("FAIL midrst_event_count: got %0h expected %0h", event_count, exp_events); end
  endtask

  task automatic test_wrap_saturate();
    logic seen;
    logic [31:0] ph;
    int bad_frames;
    logic [7:0] last_cnt_byte;
    apply_reset();
    run_enable = 1'b1;
    bad_frames = 0;
    last_cnt_byte = 8'h00;
    for (int i = 0; i < NS; i++) mem[i] = 14'($urandom_range(0, 16383));
    for (int e = 0; e < 256; e++) begin
      ph = $urandom;
      build_frame(exp_events, ph);
      start_event(ph, seen);
      collect_frame(0, 0, 0);
      exp_events = exp_events + 8'd1;
      if (timed_out || first_diff() >= 0) bad_frames++;
      if (got_q.size() > 2) last_cnt_byte = got_q[2];
    end
    n_checks++; if (bad_frames !== 0) begin n_fail++; $display("FAIL wrap_frames: got %0d bad frames expected 0", bad_frames); end
    n_checks++; if (last_cnt_byte !== 8'hFF) begin n_fail++; $display("FAIL wrap_count_byte: got %0h expected ff", last_cnt_byte); end
    n_checks++; if (event_count !== exp_events) begin n_fail++; $display("FAIL wrap_event_count: got %0h expected %0h", event_count, exp_events); end
    @(negedge clk) force dut.drop_count = 16'hFFFE;
    @(posedge clk); #1 release dut.drop_count;
    exp_drops = 16'hFFFE;
    run_enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1 trig_in = 1'b1;
      @(posedge clk); #1 trig_in = 1'b0;
      if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
      @(negedge clk);
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL saturate_drop_count: got %0h expected %0h", drop_count, exp_drops); end
    end
    run_enable = 1'b1;
  endtask

  initial begin
    exp_events = 8'h00;
    exp_drops = 16'h0000;
    test_reset();
    test_single_event();
    test_backpressure();
    test_trig_while_busy();
    test_run_disable();
    test_reset_mid_frame();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
